// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: FIFO-buffered command sequencer wrapping a combinational 4-bit ALU as an accumulator machine.
// Define ALU_CMD_SEQ_STICKY_OF_EN to make flag_o sticky until the next ld command.
module alu_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_b,
    input  logic                     cmd_ld,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [3:0]               alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_c_out,
    input  logic                     alu_of,
    output logic [3:0]               acc,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     flag_o,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [3:0]    r_acc, r_alu_a, r_alu_b;
    logic [2:0]    r_alu_op;
    logic          r_flag_z, r_flag_c, r_flag_o, r_rsp_valid;
    logic          w_push, w_pop;
    logic [7:0]    w_head;

    assign w_head    = r_mem[r_rp];
    assign cmd_ready = r_count != (AW+1)'(DEPTH);
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = r_state == ISSUE;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign acc       = r_acc;
    assign rsp_data  = r_acc;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_o    = r_flag_o;
    assign rsp_valid = r_rsp_valid;
    assign count     = r_count;
    assign busy      = (r_state != IDLE) || (r_count != '0);

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= {cmd_ld, cmd_op, cmd_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_o    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            case (r_state)
                IDLE: if (r_count != '0) begin
                    r_alu_a  <= r_acc;
                    r_alu_b  <= w_head[3:0];
                    r_alu_op <= w_head[6:4];
                    r_state  <= ISSUE;
                end
                ISSUE: begin
                    // head is still at r_rp here; it is popped on this same edge
                    r_acc    <= w_head[7] ? w_head[3:0] : alu_result;
                    r_flag_z <= w_head[7] ? r_flag_z : alu_zero;
                    r_flag_c <= w_head[7] ? r_flag_c : alu_c_out;
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
                    r_flag_o <= w_head[7] ? 1'b0 : (r_flag_o | alu_of);
`else
                    r_flag_o <= w_head[7] ? r_flag_o : alu_of;
`endif
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed bench for alu_cmd_seq with a behavioural 4-bit ALU attached.
module tb_alu_cmd_seq;
    logic       clk = 0, rst = 1;
    logic       cmd_valid = 0, cmd_ready, cmd_ld = 0;
    logic [2:0] cmd_op = 0, alu_op;
    logic [3:0] cmd_b = 0, alu_a, alu_b, alu_result, acc, rsp_data;
    logic       alu_zero, alu_c_out, alu_of;
    logic       flag_z, flag_c, flag_o, rsp_valid, rsp_ready = 0, busy;
    logic [2:0] count;
    int         n_err = 0, n_chk = 0;

    alu_cmd_seq #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_b(cmd_b), .cmd_ld(cmd_ld),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_c_out(alu_c_out), .alu_of(alu_of),
        .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .flag_o(flag_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // Reference ALU: 000 add, 001 sub (c = borrow), 010 and, 011 or, 100 xor, 101 not a, 110 a<b, 111 a==b
    logic [4:0] t;
    always_comb begin
        t = '0;
        alu_of = 1'b0;
        case (alu_op)
            3'd0: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_of = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]); end
            3'd1: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_of = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]); end
            3'd2: t = {1'b0, alu_a & alu_b};
            3'd3: t = {1'b0, alu_a | alu_b};
            3'd4: t = {1'b0, alu_a ^ alu_b};
            3'd5: t = {1'b0, ~alu_a};
            3'd6: t = {4'b0, alu_a < alu_b};
            default: t = {4'b0, alu_a == alu_b};
        endcase
        alu_result = t[3:0];
        alu_c_out  = t[4];
        alu_zero   = t[3:0] == 4'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic ld, input logic [2:0] op, input logic [3:0] b);
        @(negedge clk);
        cmd_valid = 1; cmd_ld = ld; cmd_op = op; cmd_b = b;
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic get_rsp(output logic [3:0] d);
        int n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk("rsp_valid", rsp_valid, 1);
        d = rsp_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        logic [3:0] exp_q [5];
        logic       seen;
        exp_q = '{4'd1, 4'd2, 4'd4, 4'd7, 4'd11};
        repeat (2) @(negedge clk);
        chk("rst_acc", acc, 0);
        chk("rst_flags", {flag_z, flag_c, flag_o}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 0;
        rsp_ready = 1;

        push(1, 3'd0, 4'd3);
        chk("lat_e0_valid", rsp_valid, 0);
        chk("lat_e0_count", count, 1);
        chk("lat_e0_busy", busy, 1);
        @(posedge clk); #1;
        chk("lat_e1_valid", rsp_valid, 0);
        chk("lat_e1_alu_b", alu_b, 3);
        @(posedge clk); #1;
        chk("lat_e2_valid", rsp_valid, 1);
        chk("lat_e2_data", rsp_data, 3);
        @(posedge clk); #1;
        chk("lat_e3_valid", rsp_valid, 0);

        push(0, 3'd0, 4'd5);
        get_rsp(d);
        chk("add_data", d, 8);
        chk("add_flags", {flag_z, flag_c, flag_o}, 3'b001);

        push(0, 3'd1, 4'd8);
        get_rsp(d);
        chk("sub_data", d, 0);
        chk("sub_zc", {flag_z, flag_c}, 2'b10);
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
        chk("sub_o", flag_o, 1);
`else
        chk("sub_o", flag_o, 0);
`endif
        push(1, 3'd0, 4'd0);
        get_rsp(d);
        chk("ld0_data", d, 0);
        chk("ld0_o", flag_o, 0);
        chk("ld0_z_held", flag_z, 1);
        push(0, 3'd0, 4'd0);
        get_rsp(d);
        chk("add0_flags", {flag_z, flag_c, flag_o}, 3'b100);

        rsp_ready = 0;
        push(1, 3'd0, 4'd1);
        push(0, 3'd0, 4'd1);
        push(0, 3'd0, 4'd2);
        push(0, 3'd0, 4'd3);
        push(0, 3'd0, 4'd4);
        chk("bp_count", count, 4);
        chk("bp_ready", cmd_ready, 0);
        chk("bp_first_valid", rsp_valid, 1);
        chk("bp_first_data", rsp_data, 1);
        push(1, 3'd0, 4'd15);
        chk("bp_refused_count", count, 4);
        rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            get_rsp(d);
            chk("drain", d, exp_q[i]);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_idle_valid", rsp_valid, 0);
        chk("drain_idle_count", count, 0);
        chk("drain_idle_busy", busy, 0);
        chk("drain_acc", acc, 11);

        push(1, 3'd0, 4'd7);
        @(posedge clk); #1;
        chk("issue_alu_b", alu_b, 7);
        rst = 1;
        #1;
        chk("arst_acc", acc, 0);
        chk("arst_count", count, 0);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid) seen = 1; end
        chk("arst_no_rsp", seen, 0);
        chk("arst_acc_after", acc, 0);

        push(1, 3'd0, 4'd2);
        get_rsp(d);
        chk("ld2_data", d, 2);
        push(0, 3'd6, 4'd9);
        push(0, 3'd7, 4'd2);
        get_rsp(d);
        chk("op6_alu", {alu_a, alu_op, alu_b}, {4'd2, 3'd6, 4'd9});
        chk("op6_data", d, 1);
        get_rsp(d);
        chk("op7_alu", {alu_a, alu_op, alu_b}, {4'd1, 3'd7, 4'd2});
        chk("op7_data", d, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
